// File: rtl/xor_arbiter_pkg.sv
// Shared definitions for the two-requester XOR reduction arbiter.
package xor_arbiter_pkg;

  localparam int DATA_W    = 800;          // 100 input bytes per beat
  localparam int RSP_W     = 160;          // 20 result bytes per beat
  localparam int BYTES_OUT = RSP_W / 8;
  localparam int FOLD      = 5;            // input bytes folded into each result byte
  localparam int GROUP_W   = FOLD * 8;

  localparam logic REQ_ID0 = 1'b0;         // AES path
  localparam logic REQ_ID1 = 1'b1;         // SHA3 theta path

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  // XOR of five consecutive bytes, most significant byte first.
  function automatic logic [7:0] xor5(input logic [GROUP_W-1:0] grp);
    return grp[39:32] ^ grp[31:24] ^ grp[23:16] ^ grp[15:8] ^ grp[7:0];
  endfunction

endpackage

// File: rtl/xor_arbiter_xor_unit.sv
// XORUnit: folds 100 input bytes into 20 result bytes, byte i = XOR of bytes 5i..5i+4.
module xor_arbiter_xor_unit
  import xor_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [RSP_W-1:0]  result
);

  // Purely combinational reduction; byte 0 sits in the most significant lane.
  always_comb begin
    result = '0;
    for (int i = 0; i < BYTES_OUT; i++) begin
      result[RSP_W-1-8*i -: 8] = xor5(data[DATA_W-1-GROUP_W*i -: GROUP_W]);
    end
  end

endmodule

// File: rtl/xor_arbiter.sv
// Two-requester arbiter in front of a single shared XOR reduction unit, with
// optional transaction locking and a one-entry result register.
module xor_arbiter
  import xor_arbiter_pkg::*;
#(
  parameter int LOCK_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RSP_W-1:0]  rsp_data,
  output logic              rsp_id,
  output logic              rsp_last
);

  state_t            state;
  logic              last_grant;
  logic              can_accept;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              sel_id;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [RSP_W-1:0]  xor_result;

  // The result register can take a new beat when empty or draining this cycle.
  assign can_accept = !rsp_valid || rsp_ready;

  // Grant selection: lock owner only, otherwise round robin on ties.
  // Gated by rst_n so no ready is offered while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && can_accept) begin
      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            if (last_grant == REQ_ID1) grant0 = 1'b1;
            else                       grant1 = 1'b1;
          end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
          end
        end
        LOCK0:   grant0 = req0_valid;
        LOCK1:   grant1 = req1_valid;
        default: ;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;
  assign sel_id     = grant1 ? REQ_ID1 : REQ_ID0;
  assign sel_last   = grant1 ? req1_last : req0_last;
  assign sel_data   = grant1 ? req1_data : req0_data;

  xor_arbiter_xor_unit u_xor_unit (
    .data   (sel_data),
    .result (xor_result)
  );

  // Arbitration FSM and round-robin history, advanced on every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ_ID1;
    end else if (accept) begin
      last_grant <= sel_id;
      if (LOCK_EN != 0) begin
        case (state)
          IDLE: begin
            if (!sel_last) state <= (sel_id == REQ_ID1) ? LOCK1 : LOCK0;
          end
          LOCK0, LOCK1: begin
            if (sel_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Result register: load on accept, clear on drain, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_last  <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= xor_result;
      rsp_id    <= sel_id;
      rsp_last  <= sel_last;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_arbiter.sv
// Directed bench for xor_arbiter with a transaction-level reference model.
module tb_xor_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_last;
  logic [799:0] req0_data;
  logic         req1_valid, req1_ready, req1_last;
  logic [799:0] req1_data;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_last;
  logic [159:0] rsp_data;

  int errors = 0;
  int checks = 0;

  xor_arbiter #(.LOCK_EN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_last   (rsp_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_owner;   // -1: nobody holds the lock, else requester number
  int           m_prev;    // requester granted most recently
  logic         m_rv, m_rid, m_rlast;
  logic [159:0] m_rdata;

  function automatic logic [159:0] fold(input logic [799:0] d);
    byte unsigned bytes_in[100];
    logic [159:0] r;
    for (int k = 0; k < 100; k++) bytes_in[k] = d[799-8*k -: 8];
    r = '0;
    for (int i = 0; i < 20; i++) begin
      byte unsigned acc = 0;
      for (int j = 0; j < 5; j++) acc = acc ^ bytes_in[5*i+j];
      r[159-8*i -: 8] = acc;
    end
    return r;
  endfunction

  // Which requester the rules allow this cycle (-1 for none).
  function automatic int who_wins();
    if (!rst_n) return -1;
    if (m_rv && !rsp_ready) return -1;
    if (m_owner == 0) return req0_valid ? 0 : -1;
    if (m_owner == 1) return req1_valid ? 1 : -1;
    if (req0_valid && req1_valid) return (m_prev == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(negedge rst_n) begin
    m_owner = -1; m_prev = 1; m_rv = 1'b0; m_rid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      int w;
      logic lst;
      w = who_wins();
      if (w >= 0) begin
        lst     = (w == 0) ? req0_last : req1_last;
        m_rv    = 1'b1;
        m_rdata = fold((w == 0) ? req0_data : req1_data);
        m_rid   = (w == 1);
        m_rlast = lst;
        m_prev  = w;
        if (m_owner < 0 && !lst) m_owner = w;
        else if (m_owner == w && lst) m_owner = -1;
      end else if (rsp_ready) begin
        m_rv = 1'b0;
      end
    end
  end

  // Cycle-by-cycle compare, mid-cycle; also logs drained responses.
  logic         drained_id[$];
  logic [159:0] drained_data[$];

  always @(negedge clk) begin
    int w;
    w = who_wins();
    check("req0_ready", req0_ready, w == 0);
    check("req1_ready", req1_ready, w == 1);
    check("rsp_valid", rsp_valid, m_rv);
    if (m_rv || !rst_n) begin
      check("rsp_data", rsp_data, m_rdata);
      check("rsp_id", rsp_id, m_rid);
      check("rsp_last", rsp_last, m_rlast);
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      drained_id.push_back(rsp_id);
      drained_data.push_back(rsp_data);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [799:0] fill(input byte unsigned b);
    logic [799:0] d;
    for (int k = 0; k < 100; k++) d[799-8*k -: 8] = b;
    return d;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_last = 0; req0_data = '0;
    req1_valid = 0; req1_last = 0; req1_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    rsp_ready = 1;
    step(2);
    rst_n = 1;
    step(1);
    drained_id.delete();
    drained_data.delete();
  endtask

  logic [799:0] pat;

  initial begin
    rst_n = 0;
    idle_inputs();
    rsp_ready = 0;
    step(2);
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_ready", {req0_ready, req1_ready}, 0);
    step(1);
    rst_n = 1;
    rsp_ready = 1;
    step(1);

    // Single requester, all bytes 0x01.
    req0_valid = 1; req0_last = 1; req0_data = fill(8'h01);
    step(1);
    idle_inputs();
    @(negedge clk);
    check("t1_valid", rsp_valid, 1);
    check("t1_data", rsp_data, {20{8'h01}});
    check("t1_id", rsp_id, 0);
    check("t1_last", rsp_last, 1);
    step(2);

    // Round robin out of reset, bytes 0x11..0x15 repeating.
    do_reset();
    for (int k = 0; k < 100; k++) pat[799-8*k -: 8] = 8'h11 + 8'(k % 5);
    req0_valid = 1; req0_last = 1; req0_data = pat;
    req1_valid = 1; req1_last = 1; req1_data = pat;
    step(4);
    idle_inputs();
    step(2);
    check("t2_count", drained_id.size(), 4);
    if (drained_id.size() == 4) begin
      check("t2_id0", drained_id[0], 0);
      check("t2_id1", drained_id[1], 1);
      check("t2_id2", drained_id[2], 0);
      check("t2_id3", drained_id[3], 1);
      check("t2_data", drained_data[3], {20{8'h11}});
    end

    // Locked two-beat transaction from requester 1 while requester 0 waits.
    do_reset();
    req0_valid = 1; req0_last = 1; req0_data = fill(8'h05);
    step(1);
    idle_inputs();
    step(1);
    drained_id.delete();
    drained_data.delete();
    req0_valid = 1; req0_last = 1; req0_data = fill(8'h07);
    req1_valid = 1; req1_last = 0; req1_data = fill(8'h0f);
    step(1);
    req1_last = 1; req1_data = fill(8'h30);
    @(negedge clk);
    check("t3_r0_locked_out", req0_ready, 0);
    check("t3_r1_ready", req1_ready, 1);
    step(1);
    req1_valid = 0;
    step(1);
    req0_valid = 0;
    step(2);
    check("t3_count", drained_id.size(), 3);
    if (drained_id.size() == 3) begin
      check("t3_id0", drained_id[0], 1);
      check("t3_id1", drained_id[1], 1);
      check("t3_id2", drained_id[2], 0);
      check("t3_data1", drained_data[1], {20{8'h30}});
      check("t3_data2", drained_data[2], {20{8'h07}});
    end

    // Backpressure for three cycles, then drain and accept together.
    rsp_ready = 0;
    req0_valid = 1; req0_last = 1; req0_data = fill(8'h01);
    step(1);
    req0_data = fill(8'h03);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_hold_data", rsp_data, {20{8'h01}});
      check("t4_hold_ready", {req0_ready, req1_ready}, 0);
      step(1);
    end
    rsp_ready = 1;
    @(negedge clk);
    check("t4_accept_on_drain", req0_ready, 1);
    step(1);
    idle_inputs();
    @(negedge clk);
    check("t4_new_data", rsp_data, {20{8'h03}});
    check("t4_new_valid", rsp_valid, 1);
    step(2);

    // Reset while locked to requester 0 with a held result.
    rsp_ready = 0;
    req0_valid = 1; req0_last = 0; req0_data = fill(8'h44);
    step(1);
    req0_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check("t5_valid_cleared", rsp_valid, 0);
    check("t5_ready_in_reset", {req0_ready, req1_ready}, 0);
    step(1);
    rst_n = 1;
    rsp_ready = 1;
    step(1);
    req0_valid = 1; req0_last = 1; req0_data = fill(8'h09);
    req1_valid = 1; req1_last = 1; req1_data = fill(8'h0a);
    @(negedge clk);
    check("t5_tie_req0", req0_ready, 1);
    check("t5_tie_req1", req1_ready, 0);
    step(1);
    idle_inputs();
    step(1);
    idle_inputs();
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
